// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - bi, one bit per clock, LSB first.
// Result, borrow-out and signed overflow stay registered until the next completion.
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bi,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bo,
  output logic         ovf
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         r_state, w_state_next;
  logic [N-1:0]   r_a, r_b, r_res, r_diff, w_res_next;
  logic [CW-1:0]  r_cnt;
  logic           r_br, r_bo, r_ovf, r_done;
  logic           w_bit_a, w_bit_b, w_d, w_br_next, w_last, w_accept;

  always_comb begin
    w_bit_a   = r_a[0];
    w_bit_b   = r_b[0];
    w_d       = w_bit_a ^ w_bit_b ^ r_br;
    w_br_next = (~w_bit_a & w_bit_b) | (~(w_bit_a ^ w_bit_b) & r_br);
    w_accept  = (r_state == IDLE) && start;
    w_last    = (r_state == SHIFT) && (r_cnt == CW'(N - 1));
    // Shift-then-patch keeps the MSB insert valid for N = 1.
    w_res_next        = r_res >> 1;
    w_res_next[N-1]   = w_d;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_next = SHIFT;
      SHIFT:   if (w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_res  <= '0;
      r_diff <= '0;
      r_bo   <= 1'b0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_br  <= bi;
        r_cnt <= '0;
        r_res <= '0;
      end else if (r_state == SHIFT) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_br  <= w_br_next;
        r_res <= w_res_next;
        r_cnt <= r_cnt + CW'(1);
      end
      // On the MSB step r_br is the borrow into the MSB, w_br_next the borrow out.
      if (w_last) begin
        r_diff <= w_res_next;
        r_bo   <= w_br_next;
        r_ovf  <= r_br ^ w_br_next;
      end
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = r_done;
  assign diff = r_diff;
  assign bo   = r_bo;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Checks serial_subtractor at N=1, 4 and 8 against an arithmetic reference model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic       bi;
  logic       st1, st4, st8;

  logic       busy1, done1, bo1, ovf1;
  logic [0:0] diff1;
  logic       busy4, done4, bo4, ovf4;
  logic [3:0] diff4;
  logic       busy8, done8, bo8, ovf8;
  logic [7:0] diff8;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] prev_d   [3];
  logic       prev_bo  [3];
  logic       prev_ovf [3];

  always #5 clk = ~clk;

  serial_subtractor #(.N(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a[0:0]), .b(b[0:0]), .bi(bi),
    .busy(busy1), .done(done1), .diff(diff1), .bo(bo1), .ovf(ovf1));
  serial_subtractor #(.N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .a(a[3:0]), .b(b[3:0]), .bi(bi),
    .busy(busy4), .done(done4), .diff(diff4), .bo(bo4), .ovf(ovf4));
  serial_subtractor #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .a(a), .b(b), .bi(bi),
    .busy(busy8), .done(done8), .diff(diff8), .bo(bo8), .ovf(ovf8));

  function automatic int idx(int w);
    return (w == 1) ? 0 : (w == 4) ? 1 : 2;
  endfunction

  function automatic logic get_busy(int w);
    return (w == 1) ? busy1 : (w == 4) ? busy4 : busy8;
  endfunction
  function automatic logic get_done(int w);
    return (w == 1) ? done1 : (w == 4) ? done4 : done8;
  endfunction
  function automatic logic get_bo(int w);
    return (w == 1) ? bo1 : (w == 4) ? bo4 : bo8;
  endfunction
  function automatic logic get_ovf(int w);
    return (w == 1) ? ovf1 : (w == 4) ? ovf4 : ovf8;
  endfunction
  function automatic logic [7:0] get_diff(int w);
    return (w == 1) ? {7'b0, diff1} : (w == 4) ? {4'b0, diff4} : diff8;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 1) st1 = v;
    else if (w == 4) st4 = v;
    else st8 = v;
  endtask

  task automatic chk(input string tag, input int w, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s (N=%0d): observed %0h expected %0h", tag, w, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input int w, input logic [7:0] ta, input logic [7:0] tb2, input logic tbi,
                       output logic [7:0] d, output logic ebo, output logic eovf);
    int mask, half, ua, ub, sa, sb, ib, r;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    ua   = int'(ta) & mask;
    ub   = int'(tb2) & mask;
    ib   = tbi ? 1 : 0;
    r    = ua - ub - ib;
    d    = 8'(r & mask);
    ebo  = (ua < ub + ib);
    sa   = (ua >= half) ? ua - (1 << w) : ua;
    sb   = (ub >= half) ? ub - (1 << w) : ub;
    r    = sa - sb - ib;
    eovf = (r < -half) || (r > half - 1);
  endtask

  task automatic check_held(input string tag, input int w);
    chk({tag, "_diff"}, w, get_diff(w), prev_d[idx(w)]);
    chk({tag, "_bo"},   w, get_bo(w),   prev_bo[idx(w)]);
    chk({tag, "_ovf"},  w, get_ovf(w),  prev_ovf[idx(w)]);
  endtask

  task automatic check_zero(input string tag, input int w);
    chk({tag, "_busy"}, w, get_busy(w), 0);
    chk({tag, "_done"}, w, get_done(w), 0);
    chk({tag, "_diff"}, w, get_diff(w), 0);
    chk({tag, "_bo"},   w, get_bo(w),   0);
    chk({tag, "_ovf"},  w, get_ovf(w),  0);
  endtask

  // Steps edges after the accepting edge until done; returns the edge count.
  task automatic wait_done(input int w, input bit poke, output int edges);
    bit got = 0;
    edges = 0;
    for (int e = 0; e < w + 6 && !got; e++) begin
      @(posedge clk); #1;
      edges++;
      chk("busy_done_excl", w, get_busy(w) & get_done(w), 0);
      if (get_done(w)) got = 1;
      else begin
        chk("busy_during", w, get_busy(w), 1);
        check_held("held", w);
        if (poke) begin
          set_start(w, 1'b1);
          a  = 8'($urandom);
          b  = 8'($urandom);
          bi = 1'($urandom);
        end
      end
    end
    chk("done_seen", w, got, 1);
  endtask

  task automatic finish_result(input int w, input logic [7:0] ed, input logic ebo, input logic eovf);
    chk("res_diff", w, get_diff(w), ed);
    chk("res_bo",   w, get_bo(w),   ebo);
    chk("res_ovf",  w, get_ovf(w),  eovf);
    chk("res_busy", w, get_busy(w), 0);
    prev_d[idx(w)]   = ed;
    prev_bo[idx(w)]  = ebo;
    prev_ovf[idx(w)] = eovf;
  endtask

  task automatic run_op(input int w, input logic [7:0] ta, input logic [7:0] tb2, input logic tbi,
                        input bit poke);
    logic [7:0] ed; logic ebo, eovf; int edges;
    model(w, ta, tb2, tbi, ed, ebo, eovf);
    @(negedge clk);
    a = ta; b = tb2; bi = tbi;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    chk("busy_after_start", w, get_busy(w), 1);
    chk("done_low_start",   w, get_done(w), 0);
    set_start(w, 1'b0);
    a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
    wait_done(w, poke, edges);
    set_start(w, 1'b0);
    chk("latency", w, edges, w);
    finish_result(w, ed, ebo, eovf);
    @(posedge clk); #1;
    chk("done_one_cycle", w, get_done(w), 0);
    chk("idle_after",     w, get_busy(w), 0);
  endtask

  task automatic back_to_back(input int w, input logic [7:0] a1, input logic [7:0] b1,
                              input logic [7:0] a2, input logic [7:0] b2);
    logic [7:0] ed1, ed2; logic ebo1, eovf1, ebo2, eovf2; int edges;
    model(w, a1, b1, 1'b0, ed1, ebo1, eovf1);
    model(w, a2, b2, 1'b0, ed2, ebo2, eovf2);
    @(negedge clk);
    a = a1; b = b1; bi = 1'b0;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    chk("b2b_busy1", w, get_busy(w), 1);
    a = a2; b = b2;
    wait_done(w, 1'b0, edges);
    chk("b2b_latency1", w, edges, w);
    finish_result(w, ed1, ebo1, eovf1);
    @(posedge clk); #1;
    chk("b2b_restart_busy", w, get_busy(w), 1);
    chk("b2b_restart_done", w, get_done(w), 0);
    set_start(w, 1'b0);
    a = 8'($urandom); b = 8'($urandom);
    wait_done(w, 1'b0, edges);
    chk("b2b_period", w, edges + 1, w + 1);
    finish_result(w, ed2, ebo2, eovf2);
    @(posedge clk); #1;
    chk("b2b_done_one_cycle", w, get_done(w), 0);
  endtask

  task automatic reset_mid(input int w);
    int k;
    k = (w > 1) ? 2 : 0;
    @(negedge clk);
    a = 8'hA5; b = 8'h3C; bi = 1'b1;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    repeat (k) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_busy", w, get_busy(w), 1);
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid", w);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      prev_d[i] = '0; prev_bo[i] = 1'b0; prev_ovf[i] = 1'b0;
    end
    for (int e = 0; e < w + 2; e++) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", w, get_done(w), 0);
      chk("idle_after_rst",    w, get_busy(w), 0);
    end
    run_op(w, 8'd10, 8'd4, 1'b0, 1'b0);
  endtask

  initial begin
    int widths [3];
    widths = '{4, 1, 8};
    rst_n = 1'b0;
    st1 = 1'b0; st4 = 1'b0; st8 = 1'b0;
    a = '0; b = '0; bi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      prev_d[i] = '0; prev_bo[i] = 1'b0; prev_ovf[i] = 1'b0;
    end
    #12;
    foreach (widths[i]) check_zero("reset", widths[i]);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (widths[i]) begin
      int w;
      w = widths[i];
      run_op(w, 8'd7, 8'd3,  1'b0, 1'b0);
      run_op(w, 8'd3, 8'd7,  1'b0, 1'b0);
      run_op(w, 8'd8, 8'd1,  1'b0, 1'b0);
      run_op(w, 8'd7, 8'd15, 1'b0, 1'b0);
      run_op(w, 8'd0, 8'd0,  1'b1, 1'b0);
      run_op(w, 8'd5, 8'd5,  1'b0, 1'b0);
      run_op(w, 8'd9, 8'd2,  1'b0, 1'b1);
      back_to_back(w, 8'd6, 8'd1, 8'd1, 8'd2);
      reset_mid(w);
      for (int r = 0; r < 10; r++)
        run_op(w, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
